// File: rtl/y86_decode_stage.sv
// Y86-64 decode/register-file stage: register IDs, forwarded operands, W-stage writeback and the E pipeline register.
// Optional macro DECODE_BUBBLE_EN adds E_bubble / E_stall controls on the E register.
module y86_decode_stage #(
  parameter int NREG = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [144:0] D,
  input  logic [3:0]   e_dstE,
  input  logic [63:0]  e_valE,
  input  logic [3:0]   M_dstE,
  input  logic [63:0]  M_valE,
  input  logic [3:0]   M_dstM,
  input  logic [63:0]  m_valM,
  input  logic [3:0]   W_dstE,
  input  logic [63:0]  W_valE,
  input  logic [3:0]   W_dstM,
  input  logic [63:0]  W_valM,
`ifdef DECODE_BUBBLE_EN
  input  logic         E_bubble,
  input  logic         E_stall,
`endif
  output logic [216:0] E
);

  localparam logic [3:0] ID_NONE = 4'hF;
  localparam logic [3:0] ID_RSP  = 4'h4;
  localparam logic [216:0] BUBBLE = {1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0,
                                     ID_NONE, ID_NONE, ID_NONE, ID_NONE};

  logic        dValid;
  logic [3:0]  dIcode, dIfun, dRa, dRb;
  logic [63:0] dValC, dValP;

  assign dValid = D[144];
  assign dIcode = D[143:140];
  assign dIfun  = D[139:136];
  assign dRa    = D[135:132];
  assign dRb    = D[131:128];
  assign dValC  = D[127:64];
  assign dValP  = D[63:0];

  logic [63:0]  regFile_q [NREG];
  logic [216:0] eBundle_q, eBundle_d;
  logic [3:0]   srcA, srcB, dstE, dstM;
  logic [63:0]  valA, valB;

  always_comb begin
    srcA = ID_NONE;
    srcB = ID_NONE;
    dstE = ID_NONE;
    dstM = ID_NONE;
    case (dIcode)
      4'h2: begin srcA = dRa; dstE = dRb; end
      4'h3: dstE = dRb;
      4'h4: begin srcA = dRa; srcB = dRb; end
      4'h5: begin srcB = dRb; dstM = dRa; end
      4'h6: begin srcA = dRa; srcB = dRb; dstE = dRb; end
      4'h8: begin srcB = ID_RSP; dstE = ID_RSP; end
      4'h9: begin srcA = ID_RSP; srcB = ID_RSP; dstE = ID_RSP; end
      4'hA: begin srcA = dRa; srcB = ID_RSP; dstE = ID_RSP; end
      4'hB: begin srcA = ID_RSP; srcB = ID_RSP; dstE = ID_RSP; dstM = dRa; end
      default: ;
    endcase
  end

  // Youngest producer wins; ID F is filtered first so it never matches a stage.
  function automatic logic [63:0] fwdRead(input logic [3:0] src);
    if (src == ID_NONE)     return 64'd0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else if (32'(src) < NREG) return regFile_q[src];
    else                    return 64'd0;
  endfunction

  always_comb begin
    valA = (dIcode == 4'h7 || dIcode == 4'h8) ? dValP : fwdRead(srcA);
    valB = fwdRead(srcB);
    eBundle_d = dValid ? {dValid, dIcode, dIfun, dValC, valA, valB, dstE, dstM, srcA, srcB}
                       : BUBBLE;
  end

  // Port M is tested first so it overrides port E when both hit one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regFile_q[i] <= 64'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (W_dstM == 4'(i))      regFile_q[i] <= W_valM;
        else if (W_dstE == 4'(i)) regFile_q[i] <= W_valE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eBundle_q <= BUBBLE;
`ifdef DECODE_BUBBLE_EN
    end else if (E_bubble) begin
      eBundle_q <= BUBBLE;
    end else if (!E_stall) begin
      eBundle_q <= eBundle_d;
`else
    end else begin
      eBundle_q <= eBundle_d;
`endif
    end
  end

  assign E = eBundle_q;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Self-checking bench for y86_decode_stage: directed scenarios plus randomized traffic vs. an instruction-level model.
module tb_y86_decode_stage;

  logic         clk;
  logic         rst_n;
  logic [144:0] D;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [216:0] E;
`ifdef DECODE_BUBBLE_EN
  logic         E_bubble;
  logic         E_stall;
`endif

  int vectorCount;
  int miscompareCount;
  logic [63:0] refRegs [15];

  localparam logic [216:0] TB_BUBBLE = {1'b0, 4'h1, 4'h0, 192'd0, 16'hFFFF};

  y86_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .D(D),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
`ifdef DECODE_BUBBLE_EN
    .E_bubble(E_bubble), .E_stall(E_stall),
`endif
    .E(E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [144:0] mkD(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [63:0] vc, input logic [63:0] vp);
    return {v, ic, fn, ra, rb, vc, vp};
  endfunction

  // Operand value as the architecture sees it: the newest in-flight write, else the register file.
  function automatic logic [63:0] operand(input logic [3:0] id);
    if (id == 4'hF)     return 64'd0;
    if (id == e_dstE)   return e_valE;
    if (id == M_dstM)   return m_valM;
    if (id == M_dstE)   return M_valE;
    if (id == W_dstM)   return W_valM;
    if (id == W_dstE)   return W_valE;
    return refRegs[id];
  endfunction

  function automatic logic [216:0] modelE();
    logic [3:0] ic, ra, rb, sA, sB, dE, dM;
    logic [63:0] vA, vB;
    if (!D[144]) return TB_BUBBLE;
    ic = D[143:140];
    ra = D[135:132];
    rb = D[131:128];
    sA = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    sB = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    dE = (ic inside {4'h2, 4'h3, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    dM = (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    vA = (ic == 4'h7 || ic == 4'h8) ? D[63:0] : operand(sA);
    vB = operand(sB);
    return {1'b1, ic, D[139:136], D[127:64], vA, vB, dE, dM, sA, sB};
  endfunction

  task automatic modelWrite();
    if (W_dstE != 4'hF) refRegs[W_dstE] = W_valE;
    if (W_dstM != 4'hF) refRegs[W_dstM] = W_valM;
  endtask

  task automatic checkOutput(input string tag, input logic [216:0] observed, input logic [216:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag);
    logic [216:0] expected;
    expected = modelE();
    @(posedge clk);
    modelWrite();
    #1;
    checkOutput(tag, E, expected);
  endtask

  task automatic quietInputs();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    D = mkD(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
  endtask

  function automatic logic [3:0] randId();
    if ($urandom_range(0, 3) == 0) return 4'hF;
    return 4'($urandom_range(0, 5));
  endfunction

  initial begin
    vectorCount = 0;
    miscompareCount = 0;
`ifdef DECODE_BUBBLE_EN
    E_bubble = 1'b0;
    E_stall  = 1'b0;
`endif
    quietInputs();
    D = mkD(1'b1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h55, 64'h66);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 15; i++) refRegs[i] = 64'd0;
    #1 checkOutput("resetBubble", E, TB_BUBBLE);
    @(posedge clk);
    #1 checkOutput("resetHold", E, TB_BUBBLE);
    rst_n = 1'b1;
    quietInputs();

    // Writeback into reg 2, then OPq reads it from the register file.
    W_dstE = 4'h2; W_valE = 64'h10;
    applyStimulus("wbWrite");
    quietInputs();
    D = mkD(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd0);
    applyStimulus("opqAfterWb");
    checkOutput("opqValA", 217'(E[143:80]), 217'(64'h10));
    checkOutput("opqIds", 217'({E[15:12], E[7:4], E[3:0]}), 217'(12'h323));

    // Forwarding priority on srcA = 2.
    D = mkD(1'b1, 4'h6, 4'h0, 4'h2, 4'h7, 64'd0, 64'd0);
    e_dstE = 4'h2; e_valE = 64'hAA;
    M_dstE = 4'h2; M_valE = 64'hBB;
    W_dstE = 4'h2; W_valE = 64'hCC;
    applyStimulus("fwdExecute");
    checkOutput("fwdExecuteValA", 217'(E[143:80]), 217'(64'hAA));
    e_dstE = 4'hF;
    applyStimulus("fwdMemE");
    checkOutput("fwdMemEValA", 217'(E[143:80]), 217'(64'hBB));
    M_dstM = 4'h2; m_valM = 64'hDD;
    applyStimulus("fwdMemM");
    checkOutput("fwdMemMValA", 217'(E[143:80]), 217'(64'hDD));

    // call with %rsp = 0x100 in the register file.
    quietInputs();
    W_dstE = 4'h4; W_valE = 64'h100;
    applyStimulus("rspWrite");
    quietInputs();
    D = mkD(1'b1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h40);
    applyStimulus("call");
    checkOutput("callVals", 217'({E[143:80], E[79:16]}), 217'({64'h40, 64'h100}));
    checkOutput("callIds", 217'(E[15:0]), 217'(16'h4FF4));

    // popq, then a dual write to reg 5 where port M must win.
    D = mkD(1'b1, 4'hB, 4'h0, 4'h5, 4'hF, 64'd0, 64'd0);
    applyStimulus("popq");
    checkOutput("popqIds", 217'(E[15:0]), 217'(16'h4544));
    quietInputs();
    W_dstE = 4'h5; W_valE = 64'h1;
    W_dstM = 4'h5; W_valM = 64'h2;
    applyStimulus("dualWrite");
    quietInputs();
    D = mkD(1'b1, 4'h6, 4'h0, 4'h5, 4'h5, 64'd0, 64'd0);
    applyStimulus("dualRead");
    checkOutput("dualReadValA", 217'(E[143:80]), 217'(64'h2));

    // Invalid input and halt.
    D = mkD(1'b0, 4'h6, 4'h3, 4'h1, 4'h2, 64'hDEAD, 64'hBEEF);
    applyStimulus("invalid");
    checkOutput("invalidBubble", E, TB_BUBBLE);
    D = mkD(1'b1, 4'h0, 4'h0, 4'h1, 4'h2, 64'h0, 64'h8);
    applyStimulus("halt");
    checkOutput("haltFields", 217'({E[216:212], E[15:0]}), 217'({5'b10000, 16'hFFFF}));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      D = mkD(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              randId(), randId(), {$urandom, $urandom}, {$urandom, $urandom});
      e_dstE = randId(); e_valE = {$urandom, $urandom};
      M_dstE = randId(); M_valE = {$urandom, $urandom};
      M_dstM = randId(); m_valM = {$urandom, $urandom};
      W_dstE = randId(); W_valE = {$urandom, $urandom};
      W_dstM = randId(); W_valM = {$urandom, $urandom};
      applyStimulus("random");
    end

    // Mid-cycle reset after traffic, then every register must read back 0.
    #2 rst_n = 1'b0;
    for (int i = 0; i < 15; i++) refRegs[i] = 64'd0;
    #1 checkOutput("midReset", E, TB_BUBBLE);
    @(negedge clk);
    rst_n = 1'b1;
    quietInputs();
    for (int r = 0; r < 15; r++) begin
      D = mkD(1'b1, 4'h6, 4'h0, 4'(r), 4'(r), 64'd0, 64'd0);
      applyStimulus("regAfterReset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/y86_decode_stage.md
Name: y86_decode_stage

Overview:
- Decode/register-file stage of the 5-stage pipelined Y86-64 processor; sits between the fetch pipeline register (D) and the execute pipeline register (E).
- Decodes icode to source/destination register IDs.
- Reads the 15-entry register file and resolves data hazards by forwarding from the execute, memory and writeback stages.
- Writes back W-stage results into the register file and registers the packed E bundle on each clock edge.

Parameters:
- NREG, 15, number of architectural 64-bit registers (IDs 0..14; ID 4'hF means "none").

Ports:
- clk  input  1  pipeline clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- D  input  145  fetch→decode bundle {valid[144], icode[143:140], ifun[139:136], rA[135:132], rB[131:128], valC[127:64], valP[63:0]}
- e_dstE  input  4  execute-stage destination (combinational, current cycle)
- e_valE  input  64  execute-stage ALU result
- M_dstE  input  4  memory-stage dstE
- M_valE  input  64  memory-stage valE
- M_dstM  input  4  memory-stage dstM
- m_valM  input  64  memory read data (combinational)
- W_dstE  input  4  writeback dstE; also the register-file write port E
- W_valE  input  64  writeback valE
- W_dstM  input  4  writeback dstM; also the register-file write port M
- W_valM  input  64  writeback valM
- E  output  217  decode→execute register {valid[216], icode[215:212], ifun[211:208], valC[207:144], valA[143:80], valB[79:16], dstE[15:12], dstM[11:8], srcA[7:4], srcB[3:0]}

Behaviour:
- icode encoding: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq. Any other value is treated as nop.
- srcA:
  - rA for 2, 4, 6, A
  - 4 (%rsp) for 9, B
  - else F
- srcB:
  - rB for 4, 5, 6
  - 4 for 8, 9, A, B
  - else F
- dstE:
  - rB for 2, 3, 6
  - 4 for 8, 9, A, B
  - else F
  - cmov condition is resolved in execute, not here.
- dstM: rA for 5, B; else F.
- Register-file read: combinational. ID F reads 0.
- valA selection, in priority order:
  1. icode 7 or 8 → valP
  2. srcA==e_dstE → e_valE
  3. ==M_dstM → m_valM
  4. ==M_dstE → M_valE
  5. ==W_dstM → W_valM
  6. ==W_dstE → W_valE
  7. otherwise the register file
- valB: same forwarding chain as valA (steps 2–7) on srcB, with no valP case.
- Forwarding never matches ID F.
- Register-file write on rising clk:
  - reg[W_dstE]←W_valE if W_dstE≠F
  - reg[W_dstM]←W_valM if W_dstM≠F
  - If both target the same register, W_valM wins.
- E register: loads the packed decode result on rising clk, one-cycle latency. valid, icode, ifun and valC pass through.
- Bubble on invalid input: if D.valid=0, E loads the bubble value regardless of other D fields.
  - Bubble value: valid=0, icode=1, ifun=0, valC/valA/valB=0, dstE=dstM=srcA=srcB=F.
- Halt has no special handling: icode 0 propagates normally with all IDs F, and the stage keeps clocking.
- Reset (rst_n low, asynchronous):
  - E←bubble value.
  - All 15 registers←0.
  - Release is synchronous to the next rising clk.

Optional Feature:
- Macro: DECODE_BUBBLE_EN.
- When defined:
  - Adds input E_bubble (1 bit) and input E_stall (1 bit).
  - E_bubble=1 loads the bubble value into E.
  - E_stall=1 holds E unchanged.
  - E_bubble has priority over E_stall.
  - The register-file write is unaffected by either input.
- When undefined: neither port exists, and E updates every cycle.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → E immediately equals the bubble value (icode 1, IDs F); all reg reads return 0.
- irmovq then OPq, writeback path:
  - Writeback W_dstE=2, W_valE=0x10 for one edge.
  - Then D = OPq rA=2, rB=3 with no forwarding matches.
  - Required next-edge E: valA=0x10, srcA=2, srcB=3, dstE=3.
- Forwarding priority:
  - srcA=2 with e_dstE=2/e_valE=0xAA, M_dstE=2/M_valE=0xBB, W_dstE=2/W_valE=0xCC → valA=0xAA.
  - Drop e_dstE to F → valA=0xBB.
  - Add M_dstM=2/m_valM=0xDD → valA=0xDD.
- call: icode 8, valP=0x40, rsp=0x100 in the register file → E.valA=0x40, valB=0x100, srcB=4, dstE=4, dstM=F.
- popq rA=5 → srcA=4, srcB=4, dstE=4, dstM=5. Then dual write W_dstE=5/0x1, W_dstM=5/0x2 → reg5 reads 0x2.
- Invalid/halt: D.valid=0 → E equals the bubble value. D = halt (icode 0, valid=1) → E.icode=0, all IDs F.
